// File: rtl/instr_encoder_if.sv
// Handshake bundle for instr_encoder: field-set input side and FIFO output side.
// master drives fields/in_valid/out_ready; slave (the encoder) drives the rest.
interface instr_encoder_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    fmt;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [63:0]   imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic          out_err;
    logic [CW-1:0] count;
    logic [15:0]   err_cnt;

    modport master (
        output in_valid, fmt, opcode, funct3, funct7,
        output rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err,
        input  count, err_cnt
    );

    modport slave (
        input  in_valid, fmt, opcode, funct3, funct7,
        input  rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, out_instr, out_err,
        output count, err_cnt
    );
endinterface

// File: rtl/instr_encoder.sv
// Re-encodes decoded RV64I fields into 32-bit words, buffered in a FIFO.
// Ports: clk, rst_n (async active-low), bus (instr_encoder_if.slave).
module instr_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_encoder_if.slave  bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [32:0]   mem_q [FIFO_DEPTH];
    logic [32:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    logic [31:0] enc_word;
    logic        enc_ok;
    logic        push;
    logic        pop;
    logic        empty;

    // Sign-extension checks: all bits from the top down to the
    // encodable sign bit must agree.
    logic se11, se12, se20, se31;
    assign se11 = (&bus.imm[63:11]) | ~(|bus.imm[63:11]);
    assign se12 = (&bus.imm[63:12]) | ~(|bus.imm[63:12]);
    assign se20 = (&bus.imm[63:20]) | ~(|bus.imm[63:20]);
    assign se31 = (&bus.imm[63:31]) | ~(|bus.imm[63:31]);

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (bus.fmt)
            3'd0: begin
                enc_word = {bus.funct7, bus.rs2, bus.rs1,
                            bus.funct3, bus.rd, bus.opcode};
                enc_ok   = 1'b1;
            end
            3'd1: begin
                enc_word = {bus.imm[11:0], bus.rs1,
                            bus.funct3, bus.rd, bus.opcode};
                enc_ok   = se11;
            end
            3'd2: begin
                enc_word = {bus.imm[11:5], bus.rs2, bus.rs1,
                            bus.funct3, bus.imm[4:0], bus.opcode};
                enc_ok   = se11;
            end
            3'd3: begin
                enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2,
                            bus.rs1, bus.funct3, bus.imm[4:1],
                            bus.imm[11], bus.opcode};
                enc_ok   = se12 & ~bus.imm[0];
            end
            3'd4: begin
                enc_word = {bus.imm[31:12], bus.rd, bus.opcode};
                enc_ok   = se31 & ~(|bus.imm[11:0]);
            end
            3'd5: begin
                enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11],
                            bus.imm[19:12], bus.rd, bus.opcode};
                enc_ok   = se20 & ~bus.imm[0];
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    assign empty = (count_q == '0);
    // in_ready comes from registered occupancy only; a pop while full
    // cannot make room for a push in the same cycle.
    assign push  = bus.in_valid & (count_q != FULL);
    assign pop   = bus.out_ready & ~empty;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            // Error entries carry a zero word so the head reads 0.
            mem_d[wr_ptr_q] = {~enc_ok, enc_ok ? enc_word : 32'h0};
            wr_ptr_d        = wr_ptr_q + AW'(1);
            if (!enc_ok && err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.in_ready  = (count_q != FULL);
    assign bus.out_valid = ~empty;
    assign bus.out_instr = empty ? 32'h0 : mem_q[rd_ptr_q][31:0];
    assign bus.out_err   = empty ? 1'b0  : mem_q[rd_ptr_q][32];
    assign bus.count     = count_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed field sets, queue of
// expected {err, word} entries, negedge monitor pops and compares.
module tb_instr_encoder;
    logic clk;
    logic rst_n;

    instr_encoder_if #(.FIFO_DEPTH(4)) bus ();

    instr_encoder #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [32:0] sb[$];
    int          n_cmp;
    int          n_bad;
    int          n_pop;
    logic        hold_v;
    logic [32:0] hold_e;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares head against scoreboard whenever a pop happens.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (hold_v) begin
                    chk("head_stable", {31'h0, bus.out_err, bus.out_instr},
                        {31'h0, hold_e});
                end
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 64'h1, 64'h0);
                    end else begin
                        chk("out_entry",
                            {31'h0, bus.out_err, bus.out_instr},
                            {31'h0, sb.pop_front()});
                    end
                    n_pop++;
                end
            end else begin
                chk("empty_head", {31'h0, bus.out_err, bus.out_instr},
                    64'h0);
            end
            hold_v = bus.out_valid & ~bus.out_ready;
            hold_e = {bus.out_err, bus.out_instr};
        end
    end

    task automatic drive(input logic [2:0] f, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [63:0] im);
        bus.fmt    = f;
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.rd     = d;
        bus.rs1    = s1;
        bus.rs2    = s2;
        bus.imm    = im;
    endtask

    // Offer one field set until accepted (bounded); called at posedge+1.
    task automatic send(input logic [2:0] f, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [63:0] im,
                        input logic [31:0] ew, input logic ee);
        bit acc;
        drive(f, op, f3, f7, d, s1, s2, im);
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 30 && !acc; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back({ee, ew});
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'h1, 64'h0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_done", 64'(sb.size()), 64'h0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_words [5];
    logic [31:0] w;
    int          pop_base;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_pop = 0;
        hold_v = 1'b0;
        hold_e = '0;
        bp_words[0] = 32'h00100093;
        bp_words[1] = 32'h00200113;
        bp_words[2] = 32'h00300193;
        bp_words[3] = 32'h00400213;
        bp_words[4] = 32'h00500293;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(3'd0, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 64'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_count", 64'(bus.count), 64'h0);
        chk("rst_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_errcnt", 64'(bus.err_cnt), 64'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cycle();
        chk("rst_in_ready", 64'(bus.in_ready), 64'h1);

        // Single ADD: visible right after the accepting edge.
        drive(3'd0, 7'h33, 3'h0, 7'h0, 5'd3, 5'd1, 5'd2, 64'h0);
        bus.in_valid = 1'b1;
        sb.push_back({1'b0, 32'h002081B3});
        cycle();
        bus.in_valid = 1'b0;
        chk("add_valid", 64'(bus.out_valid), 64'h1);
        chk("add_word", 64'(bus.out_instr), 64'h002081B3);
        cycle();

        send(3'd1, 7'h13, 3'h0, 7'h0, 5'd3, 5'd2, 5'd0, -64'sd1,
             32'hFFF10193, 1'b0);
        send(3'd1, 7'h13, 3'h0, 7'h0, 5'd3, 5'd2, 5'd0, 64'd2048,
             32'h0, 1'b1);
        chk("errcnt_1", 64'(bus.err_cnt), 64'h1);
        send(3'd3, 7'h63, 3'h0, 7'h0, 5'd0, 5'd1, 5'd2, 64'd8,
             32'h00208463, 1'b0);
        send(3'd3, 7'h63, 3'h0, 7'h0, 5'd0, 5'd1, 5'd2, 64'd7,
             32'h0, 1'b1);
        send(3'd3, 7'h63, 3'h0, 7'h0, 5'd0, 5'd1, 5'd2, -64'sd4096,
             32'h80208063, 1'b0);
        send(3'd3, 7'h63, 3'h0, 7'h0, 5'd0, 5'd1, 5'd2, 64'd4096,
             32'h0, 1'b1);
        send(3'd4, 7'h37, 3'h0, 7'h0, 5'd3, 5'd0, 5'd0,
             64'hFFFFFFFFABCDE000, 32'hABCDE1B7, 1'b0);
        send(3'd4, 7'h37, 3'h0, 7'h0, 5'd3, 5'd0, 5'd0,
             64'h12345001, 32'h0, 1'b1);
        send(3'd5, 7'h6F, 3'h0, 7'h0, 5'd1, 5'd0, 5'd0, 64'h800,
             32'h001000EF, 1'b0);
        send(3'd7, 7'h33, 3'h0, 7'h0, 5'd1, 5'd1, 5'd1, 64'h0,
             32'h0, 1'b1);
        drain();
        chk("errcnt_5", 64'(bus.err_cnt), 64'h5);

        // Backpressure: five offers into a four-deep FIFO.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(3'd1, 7'h13, 3'h0, 7'h0, 5'(k + 1), 5'd0, 5'd0,
                  64'(k + 1));
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (bus.in_ready) sb.push_back({1'b0, bp_words[k]});
            cycle();
        end
        chk("bp_count_full", 64'(bus.count), 64'h4);
        chk("bp_in_ready_0", 64'(bus.in_ready), 64'h0);
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_count_3", 64'(bus.count), 64'h3);
        chk("bp_in_ready_1", 64'(bus.in_ready), 64'h1);
        send(3'd1, 7'h13, 3'h0, 7'h0, 5'd5, 5'd0, 5'd0, 64'd5,
             bp_words[4], 1'b0);
        // Sustained push/pop to wrap both pointers.
        for (int k = 1; k <= 10; k++) begin
            w = {7'h0, 5'(k), 5'(k), 3'h0, 5'(k), 7'h33};
            send(3'd0, 7'h33, 3'h0, 7'h0, 5'(k), 5'(k), 5'(k), 64'h0,
                 w, 1'b0);
        end
        drain();
        chk("bp_empty", 64'(bus.count), 64'h0);

        // Reset with entries in flight.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        send(3'd7, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 64'h0,
             32'h0, 1'b1);
        send(3'd6, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 64'h0,
             32'h0, 1'b1);
        send(3'd0, 7'h33, 3'h0, 7'h0, 5'd3, 5'd1, 5'd2, 64'h0,
             32'h002081B3, 1'b0);
        chk("pre_rst_count", 64'(bus.count), 64'h3);
        chk("pre_rst_errcnt", 64'(bus.err_cnt), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(bus.count), 64'h0);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'h0);
        chk("mid_rst_errcnt", 64'(bus.err_cnt), 64'h0);
        chk("mid_rst_instr", 64'(bus.out_instr), 64'h0);
        sb.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        pop_base = n_pop;
        send(3'd5, 7'h6F, 3'h0, 7'h0, 5'd1, 5'd0, 5'd0, 64'h800,
             32'h001000EF, 1'b0);
        drain();
        repeat (3) cycle();
        chk("post_rst_pops", 64'(n_pop - pop_base), 64'h1);
        chk("post_rst_count", 64'(bus.count), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Converts decoded instruction fields (format, opcode, funct3/funct7, register indices, 64-bit sign-extended immediate) back into 32-bit RV64I instruction words. It is the inverse of `decoder`. It feeds the instruction memory loader and the decoder self-check path. Encoded words are buffered in a FIFO with valid/ready handshakes on both sides. Immediates that cannot be encoded are flagged per entry and counted.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥ 2.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: field set valid.
- `in_ready` out 1: block can accept a field set.
- `fmt` in 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- `opcode` in 7: instr[6:0].
- `funct3` in 3: instr[14:12]; ignored for U and J.
- `funct7` in 7: instr[31:25]; R only.
- `rd`, `rs1`, `rs2` in 5 each: register indices; placed only where the format has them.
- `imm` in 64: signed immediate in the form `decoder` produces (U: value already shifted left by 12).
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer takes the head entry.
- `out_instr` out 32: head entry word; 0 when empty.
- `out_err` out 1: head entry is an encode error; 0 when empty.
- `count` out clog2(FIFO_DEPTH)+1: current occupancy.
- `err_cnt` out 16: accepted erroneous entries; saturates at 0xFFFF.

## Operation
- A field set is accepted when `in_valid & in_ready`. The encoded word and error bit are pushed as one entry.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Legality checks (entry is an error on any failure):
  - I, S: imm[63:11] all equal.
  - B: imm[63:12] all equal and imm[0]=0.
  - J: imm[63:20] all equal and imm[0]=0.
  - U: imm[11:0]=0 and imm[63:31] all equal.
  - R: imm is ignored.
  - fmt 6 or 7: always an error.
- An error entry stores `out_instr`=0x00000000 and `out_err`=1. `err_cnt` increments at the accepting edge and saturates.
- FIFO behaviour:
  - Strict order.
  - Pop when `out_valid & out_ready`.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - `count` distinguishes full from empty.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `count`=0, `out_valid`=0, `out_instr`=0, `out_err`=0, `err_cnt`=0.
  - `in_ready`=1 while `rst_n` is high with an empty FIFO.
  - Entries in flight are discarded; in-flight handshakes are not completed.
- Latency: an entry accepted at edge N appears on the outputs after edge N. There is no combinational bypass from input to output.
- `in_ready` = (`count` != FIFO_DEPTH). It depends only on registered state, not on `out_ready`. When full, a simultaneous pop does not allow a same-cycle push.
- Push and pop in the same cycle with 0 < `count` < FIFO_DEPTH: `count` is unchanged and the head advances.
- Pop when empty: no effect. `out_valid`=0, and `out_instr`/`out_err` read 0.
- Head outputs are stable while `out_valid & !out_ready`.
- `err_cnt` and `count` update at the same edge as the push or pop that causes them.

## Test plan
- **R ADD:** fmt=0, opcode=0x33, f3=0, f7=0, rd=3, rs1=1, rs2=2 -> next cycle `out_valid`=1, `out_instr`=0x002081B3, `out_err`=0.
- **I ADDI:**
  - imm=-1, rd=3, rs1=2, opcode=0x13 -> 0xFFF10193.
  - Then imm=2048 -> `out_err`=1, `out_instr`=0, `err_cnt`=1.
- **B BEQ:**
  - opcode=0x63, rs1=1, rs2=2, imm=8 -> 0x00208463.
  - imm=7 -> error.
  - imm=-4096 legal; imm=4096 error.
- **U and J:**
  - LUI, opcode=0x37, rd=3, imm=0xFFFFFFFFABCDE000 -> 0xABCDE1B7.
  - imm=0x12345001 -> error.
  - JAL, opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF.
  - fmt=7 -> error.
- **Backpressure (FIFO_DEPTH=4):**
  - `out_ready`=0; offer 5 sets -> 4 accepted, `count`=4, `in_ready`=0.
  - Then `out_ready`=1 with `in_valid`=1 -> pop only; next cycle `count`=3 and `in_ready`=1.
  - All words emerge in order; pointer wrap is exercised over 10 further push/pop cycles.
- **Reset mid-operation:** with `count`=3 and `err_cnt`=2, drop `rst_n` between edges -> `count`, `out_valid`, `err_cnt` go to 0 immediately. After release, one fresh push appears alone.
